// File: rtl/snn_pkg.sv
// Shared defaults and slot geometry for the SNN weight fetch path.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package snn_pkg;

    localparam int unsigned WEIGHT_W_DEF   = 2;
    localparam int unsigned WORD_W_DEF     = 32;
    localparam int unsigned DEPTH_DEF      = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    // LSB position of weight slot 'slot' inside an SRAM word; slot 0 sits in the MSBs.
    function automatic int unsigned slot_lsb(input int unsigned word_w,
                                             input int unsigned weight_w,
                                             input int unsigned slot);
        return word_w - weight_w - slot * weight_w;
    endfunction

endpackage

// File: rtl/spike_fifo.sv
// Generic circular FIFO with occupancy output; head data is read combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: pushes are ignored when full and pops when empty; caller gates on level.
// Ports: clk_i/rst_i (sync active-high), push_vld/push_dat, pop_rdy, head_dat, level.
module spike_fifo
    import snn_pkg::*;
#(
    parameter int unsigned DAT_W = 8,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_vld,
    input  logic [DAT_W-1:0]   push_dat,
    input  logic               pop_rdy,
    output logic [DAT_W-1:0]   head_dat,
    output logic [PTR_W:0]     level
);

    localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   LVL_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    logic [DAT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push_vld && (level != FULL_LVL);
    assign pop_ok   = pop_rdy && (level != '0);
    assign head_dat = mem[rd_ptr];

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop_ok)      level <= level + LVL_ONE;
            else if (pop_ok && !push_ok) level <= level - LVL_ONE;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/weight_fetch_unit.sv
// Queues spike events and looks up each event's synaptic weight in a packed weight SRAM.
// Latency: spike offered in cycle n -> result valid in cycle n+2; 1 result/cycle sustained.
// Backpressure: spike_ready_o from registered FIFO level only; output holds while !weight_ready_i.
// Ports: config write (en_i, we_i, addr_i, d_i); spike in (spike_valid_i/spike_ready_o, axon_ind_i);
//        result out (weight_valid_o/weight_ready_i, weight_type_o, axon_ind_o); fifo_level_o.
module weight_fetch_unit
    import snn_pkg::*;
#(
    parameter int unsigned WEIGHT_W   = WEIGHT_W_DEF,
    parameter int unsigned WORD_W     = WORD_W_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned SLOTS  = WORD_W / WEIGHT_W,
    localparam int unsigned SLOT_W = $clog2(SLOTS),
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned AXON_W = ADDR_W + SLOT_W,
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [WORD_W-1:0]   d_i,
    input  logic                spike_valid_i,
    output logic                spike_ready_o,
    input  logic [AXON_W-1:0]   axon_ind_i,
    output logic                weight_valid_o,
    input  logic                weight_ready_i,
    output logic [WEIGHT_W-1:0] weight_type_o,
    output logic [AXON_W-1:0]   axon_ind_o,
    output logic [LVL_W-1:0]    fifo_level_o
);

    localparam int unsigned   LSB_W    = $clog2(WORD_W);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic [WORD_W-1:0] sram [DEPTH];
    logic              cfg_wr;
    logic              push;
    logic              pop;
    logic [AXON_W-1:0] head_axon;
    logic [ADDR_W-1:0] head_word;
    logic [SLOT_W-1:0] head_slot;
    logic [WORD_W-1:0] rd_word;
    logic [LSB_W-1:0]  sel_lsb;

    assign cfg_wr        = en_i && we_i;
    assign spike_ready_o = (fifo_level_o < FULL_LVL);
    assign push          = spike_valid_i && spike_ready_o;
    // Pop whenever the output register is free or being drained this cycle.
    assign pop           = (fifo_level_o != '0) && (!weight_valid_o || weight_ready_i);

    assign head_word = head_axon[AXON_W-1:SLOT_W];
    assign head_slot = head_axon[SLOT_W-1:0];
    // A write landing on the word being looked up wins over the stale SRAM contents.
    assign rd_word   = (cfg_wr && (addr_i == head_word)) ? d_i : sram[head_word];
    assign sel_lsb   = LSB_W'(slot_lsb(WORD_W, WEIGHT_W, 32'(head_slot)));

    // Weight memory is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (cfg_wr) sram[addr_i] <= d_i;
    end

    spike_fifo #(
        .DAT_W (AXON_W),
        .DEPTH (FIFO_DEPTH)
    ) u_spike_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (push),
        .push_dat (axon_ind_i),
        .pop_rdy  (pop),
        .head_dat (head_axon),
        .level    (fifo_level_o)
    );

    // Output register: loads on pop, holds under backpressure, clears to zero once drained.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            weight_valid_o <= 1'b0;
            weight_type_o  <= '0;
            axon_ind_o     <= '0;
        end else if (pop) begin
            weight_valid_o <= 1'b1;
            weight_type_o  <= rd_word[sel_lsb +: WEIGHT_W];
            axon_ind_o     <= head_axon;
        end else if (weight_ready_i) begin
            weight_valid_o <= 1'b0;
            weight_type_o  <= '0;
            axon_ind_o     <= '0;
        end
    end

endmodule

// File: tb/tb_weight_fetch_unit.sv
module tb_weight_fetch_unit;

    localparam int WEIGHT_W = 2;
    localparam int WORD_W   = 32;
    localparam int DEPTH    = 16;
    localparam int FD       = 4;
    localparam int SLOTS    = WORD_W / WEIGHT_W;
    localparam int AXON_W   = 8;
    localparam int LVL_W    = 3;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                rst_i = 1'b1;
    logic                en_i = 1'b0, we_i = 1'b0;
    logic [3:0]          addr_i = '0;
    logic [WORD_W-1:0]   d_i = '0;
    logic                spike_valid_i = 1'b0;
    logic                spike_ready_o;
    logic [AXON_W-1:0]   axon_ind_i = '0;
    logic                weight_valid_o;
    logic                weight_ready_i = 1'b1;
    logic [WEIGHT_W-1:0] weight_type_o;
    logic [AXON_W-1:0]   axon_ind_o;
    logic [LVL_W-1:0]    fifo_level_o;

    weight_fetch_unit u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .we_i(we_i), .addr_i(addr_i), .d_i(d_i),
        .spike_valid_i(spike_valid_i), .spike_ready_o(spike_ready_o), .axon_ind_i(axon_ind_i),
        .weight_valid_o(weight_valid_o), .weight_ready_i(weight_ready_i),
        .weight_type_o(weight_type_o), .axon_ind_o(axon_ind_o), .fifo_level_o(fifo_level_o)
    );

    // Wide-slot variant: 4-bit weights, 64-bit words, 8 words -> 7-bit axon index.
    logic        b_en = 1'b0, b_we = 1'b0;
    logic [2:0]  b_addr = '0;
    logic [63:0] b_d = '0;
    logic        b_spike_valid = 1'b0;
    logic        b_spike_ready;
    logic [6:0]  b_axon_in = '0;
    logic        b_valid;
    logic        b_ready = 1'b1;
    logic [3:0]  b_weight;
    logic [6:0]  b_axon_out;
    logic [2:0]  b_level;

    weight_fetch_unit #(.WEIGHT_W(4), .WORD_W(64), .DEPTH(8), .FIFO_DEPTH(4)) u_dut_wide (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(b_en), .we_i(b_we), .addr_i(b_addr), .d_i(b_d),
        .spike_valid_i(b_spike_valid), .spike_ready_o(b_spike_ready), .axon_ind_i(b_axon_in),
        .weight_valid_o(b_valid), .weight_ready_i(b_ready),
        .weight_type_o(b_weight), .axon_ind_o(b_axon_out), .fifo_level_o(b_level)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int got[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [WORD_W-1:0] m_mem [DEPTH];
    int q[$];
    bit m_vld = 1'b0;
    int m_w = 0;
    int m_a = 0;

    always @(posedge clk_i) begin
        automatic bit do_push;
        automatic bit do_pop;
        automatic int a;
        automatic int widx;
        automatic logic [WORD_W-1:0] word;
        if (rst_i) begin
            q.delete();
            m_vld = 1'b0; m_w = 0; m_a = 0;
        end else begin
            do_push = spike_valid_i && (q.size() < FD);
            do_pop  = (q.size() > 0) && (!m_vld || weight_ready_i);
            if (do_pop) begin
                a    = q.pop_front();
                widx = a / SLOTS;
                word = (en_i && we_i && int'(addr_i) == widx) ? d_i : m_mem[widx];
                m_w  = int'(word >> (WORD_W - WEIGHT_W * (a % SLOTS + 1))) & ((1 << WEIGHT_W) - 1);
                m_a  = a;
                m_vld = 1'b1;
            end else if (weight_ready_i) begin
                m_vld = 1'b0; m_w = 0; m_a = 0;
            end
            if (do_push) q.push_back(int'(axon_ind_i));
        end
        if (en_i && we_i) m_mem[addr_i] = d_i;
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("spike_ready", int'(spike_ready_o), int'(q.size() < FD));
            check("fifo_level", int'(fifo_level_o), q.size());
            check("weight_valid", int'(weight_valid_o), int'(m_vld));
            check("weight_type", int'(weight_type_o), m_w);
            check("axon_ind_o", int'(axon_ind_o), m_a);
            if (weight_valid_o && weight_ready_i) got.push_back(int'(axon_ind_o));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg_write(input int a, input logic [WORD_W-1:0] d);
        en_i = 1'b1; we_i = 1'b1; addr_i = 4'(a); d_i = d;
        tick();
        en_i = 1'b0; we_i = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_valid", int'(weight_valid_o), 0);
        check("rst_level", int'(fifo_level_o), 0);
        check("rst_ready", int'(spike_ready_o), 1);
        check("rst_weight", int'(weight_type_o), 0);
        check("rst_axon", int'(axon_ind_o), 0);
        rst_i = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < DEPTH; i++) cfg_write(i, '0);
        cfg_write(3, 32'h8000_0001);
        cfg_write(4, 32'hE4E4_E4E4);

        // Basic lookup: slot 0 is the MSB pair, slot 15 the LSB pair.
        weight_ready_i = 1'b1;
        spike_valid_i = 1'b1; axon_ind_i = 8'h30;
        tick();
        check("lat_not_yet", int'(weight_valid_o), 0);
        axon_ind_i = 8'h3F;
        tick();
        check("lat_valid", int'(weight_valid_o), 1);
        check("w_0x30", int'(weight_type_o), 2);
        check("a_0x30", int'(axon_ind_o), 'h30);
        spike_valid_i = 1'b0;
        tick();
        check("w_0x3F", int'(weight_type_o), 1);
        check("a_0x3F", int'(axon_ind_o), 'h3F);
        tick();
        check("idle_valid", int'(weight_valid_o), 0);
        check("idle_zero_w", int'(weight_type_o), 0);

        // Backpressure: fill queue behind a stalled output register.
        weight_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            spike_valid_i = 1'b1; axon_ind_i = 8'(8'h40 + i);
            tick();
        end
        check("bp_level", int'(fifo_level_o), 4);
        check("bp_ready", int'(spike_ready_o), 0);
        check("bp_axon", int'(axon_ind_o), 'h40);
        check("bp_weight", int'(weight_type_o), 3);
        spike_valid_i = 1'b0;
        repeat (3) tick();
        check("bp_hold_axon", int'(axon_ind_o), 'h40);
        check("bp_hold_weight", int'(weight_type_o), 3);
        got.delete();
        weight_ready_i = 1'b1;
        repeat (8) tick();
        check("bp_count", got.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < got.size()) check("bp_order", got[i], 'h40 + i);
        check("bp_drained", int'(fifo_level_o), 0);

        // Write-to-read bypass on the pop cycle.
        spike_valid_i = 1'b1; axon_ind_i = 8'h20;
        tick();
        spike_valid_i = 1'b0;
        en_i = 1'b1; we_i = 1'b1; addr_i = 4'd2; d_i = 32'h4000_0000;
        tick();
        en_i = 1'b0; we_i = 1'b0;
        check("byp_valid", int'(weight_valid_o), 1);
        check("byp_weight", int'(weight_type_o), 1);
        check("byp_axon", int'(axon_ind_o), 'h20);
        tick();

        // Reset mid-operation with queued events.
        weight_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            spike_valid_i = 1'b1; axon_ind_i = 8'(8'h50 + i);
            tick();
        end
        spike_valid_i = 1'b0;
        check("pre_rst_level", int'(fifo_level_o), 3);
        check("pre_rst_valid", int'(weight_valid_o), 1);
        rst_i = 1'b1;
        tick();
        check("mid_rst_valid", int'(weight_valid_o), 0);
        check("mid_rst_level", int'(fifo_level_o), 0);
        check("mid_rst_weight", int'(weight_type_o), 0);
        check("mid_rst_axon", int'(axon_ind_o), 0);
        check("mid_rst_ready", int'(spike_ready_o), 1);
        rst_i = 1'b0; weight_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_stale", int'(weight_valid_o), 0);
        end

        // Wide-slot configuration.
        b_en = 1'b1; b_we = 1'b1; b_addr = 3'd7; b_d = 64'hF000_0000_0000_000A;
        tick();
        b_en = 1'b0; b_we = 1'b0;
        b_spike_valid = 1'b1; b_axon_in = 7'h7F;
        tick();
        b_axon_in = 7'h70;
        tick();
        b_spike_valid = 1'b0;
        check("wide_valid", int'(b_valid), 1);
        check("wide_w_7F", int'(b_weight), 'hA);
        check("wide_a_7F", int'(b_axon_out), 'h7F);
        tick();
        check("wide_w_70", int'(b_weight), 'hF);
        check("wide_a_70", int'(b_axon_out), 'h70);
        tick();
        check("wide_drained", int'(b_valid), 0);
        check("wide_level", int'(b_level), 0);
        check("wide_ready", int'(b_spike_ready), 1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
